// File: rtl/window_streamer.sv
`default_nettype none
// ============================================================================
// window_streamer : reads an image word-by-word into a WIN-row circular line
//                   buffer and presents every WIN x WIN window in raster order.
// Revision        : 1.0
// ============================================================================
module window_streamer #(
  parameter int IMG_W  = 80,
  parameter int IMG_H  = 80,
  parameter int WIN    = 16,
  parameter int STRIDE = 1,
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic                 rd_valid,
  input  logic [31:0]          rd_data,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [WIN*WIN*8-1:0] win_data,
  output logic [7:0]           win_x,
  output logic [7:0]           win_y,
  output logic                 busy,
  output logic                 done
);
  localparam int C_WPR = IMG_W / 4;
  localparam int C_CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int C_SW  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int C_WCW = (C_WPR > 1) ? $clog2(C_WPR) : 1;
  localparam int C_XW  = $clog2(IMG_W + 1);
  localparam int C_YW  = $clog2(IMG_H + 1);
  localparam int C_LW  = $clog2(STRIDE + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_EMIT = 3'd2,
    S_LOAD = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t            r_state, w_next;
  logic [7:0]        r_line [WIN][IMG_W];
  logic              r_pending;
  logic [C_YW-1:0]   r_row;
  logic [C_WCW-1:0]  r_wcol;
  logic [C_SW-1:0]   r_top;
  logic [C_LW-1:0]   r_lcnt;
  logic [C_XW-1:0]   r_win_x;
  logic [C_YW-1:0]   r_win_y;

  logic              w_cap, w_row_end, w_fill_done, w_load_done, w_hs, w_x_last, w_y_last;
  logic [C_SW-1:0]   w_slot;

  assign w_cap       = rd_valid & r_pending;
  assign w_row_end   = w_cap && (r_wcol == C_WCW'(C_WPR - 1));
  assign w_fill_done = (r_state == S_FILL) && w_row_end && (r_row == C_YW'(WIN - 1));
  assign w_load_done = (r_state == S_LOAD) && w_row_end && (r_lcnt == C_LW'(STRIDE - 1));
  assign w_hs        = win_valid & win_ready;
  assign w_x_last    = (r_win_x == C_XW'(IMG_W - WIN));
  assign w_y_last    = (r_win_y == C_YW'(IMG_H - WIN));
  assign w_slot      = (r_state == S_LOAD) ? r_top : C_SW'(r_row);

  assign rd_addr = ADDR_W'(r_row) * ADDR_W'(C_WPR) + ADDR_W'(r_wcol);
  assign win_x   = 8'(r_win_x);
  assign win_y   = 8'(r_win_y);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    rd_en     = 1'b0;
    win_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_FILL;
      end
      S_FILL: begin
        rd_en = ~r_pending;
        if (w_fill_done) w_next = S_EMIT;
      end
      S_EMIT: begin
        win_valid = 1'b1;
        if (w_hs && w_x_last) w_next = w_y_last ? S_FIN : S_LOAD;
      end
      S_LOAD: begin
        rd_en = ~r_pending;
        if (w_load_done) w_next = S_EMIT;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_row     <= '0;
      r_wcol    <= '0;
      r_top     <= '0;
      r_lcnt    <= '0;
      r_win_x   <= '0;
      r_win_y   <= '0;
    end else begin
      if (rd_en)      r_pending <= 1'b1;
      else if (w_cap) r_pending <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row   <= '0;
            r_wcol  <= '0;
            r_top   <= '0;
            r_lcnt  <= '0;
            r_win_x <= '0;
            r_win_y <= '0;
          end
        end
        S_FILL, S_LOAD: begin
          if (w_cap) begin
            r_wcol <= w_row_end ? '0 : r_wcol + C_WCW'(1);
            if (w_row_end) r_row <= r_row + C_YW'(1);
            // In LOAD each completed row retires the oldest slot
            if (w_row_end && r_state == S_LOAD) begin
              r_top  <= (r_top == C_SW'(WIN - 1)) ? '0 : r_top + C_SW'(1);
              r_lcnt <= w_load_done ? '0 : r_lcnt + C_LW'(1);
              if (w_load_done) r_win_y <= r_win_y + C_YW'(STRIDE);
            end
          end
        end
        S_EMIT: begin
          if (w_hs) r_win_x <= w_x_last ? '0 : r_win_x + C_XW'(STRIDE);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_cap) begin
      for (int k = 0; k < 4; k++) begin
        r_line[w_slot][C_CW'({r_wcol, 2'b00}) + C_CW'(k)] <= rd_data[8*k +: 8];
      end
    end
  end

  // Window row r lives in slot (top + r) mod WIN
  always_comb begin
    win_data = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        win_data[(r*WIN + c)*8 +: 8] =
          r_line[C_SW'((int'(r_top) + r) % WIN)][C_CW'(r_win_x) + C_CW'(c)];
      end
    end
  end

endmodule
`default_nettype wire
